pipelined_control_unit: RTL and testbench

Stage-aware control unit for the 5-stage RISC-V core: decodes the ID-stage instruction into the control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers. It also contains the hazard logic:
- load-use and branch-operand stalls
- taken-branch/jump IF flush
- an optional multi-cycle MUL occupancy counter that freezes the front of the pipeline

It sits between the IF/ID register and the datapath pipeline registers, replacing the combinational decoder.

---
 rtl/pipelined_control_unit_if.sv | 47 ++++
 rtl/pipelined_control_unit.sv | 197 +++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_if.sv
// Control-unit port bundle: ID-stage decode inputs and per-stage control outputs.
// master = datapath side (drives ID fields), slave = control unit.
interface pipelined_control_unit_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  branch_taken;

    logic       pc_write;
    logic       if_id_write;
    logic       if_flush;
    logic       branch;
    logic       jump;
    logic [1:0] ex_alu_op;
    logic       ex_alu_src;
    logic       ex_mem_read;
    logic       ex_mem_write;
    logic       ex_mem_2_reg;
    logic       ex_reg_write;
    logic       mem_mem_read;
    logic       mem_mem_write;
    logic       mem_mem_2_reg;
    logic       mem_reg_write;
    logic       wb_mem_2_reg;
    logic       wb_reg_write;
    logic       mul_busy;

    modport master (
        output opcode, funct7, id_rs1, id_rs2, id_rd, branch_taken,
        input  pc_write, if_id_write, if_flush, branch, jump,
        input  ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_2_reg, ex_reg_write,
        input  mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write,
        input  wb_mem_2_reg, wb_reg_write, mul_busy
    );

    modport slave (
        input  opcode, funct7, id_rs1, id_rs2, id_rd, branch_taken,
        output pc_write, if_id_write, if_flush, branch, jump,
        output ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_2_reg, ex_reg_write,
        output mem_mem_read, mem_mem_write, mem_mem_2_reg, mem_reg_write,
        output wb_mem_2_reg, wb_reg_write, mul_busy
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Purpose: ID decode + ID/EX, EX/MEM, MEM/WB control registers + hazard/flush/MUL-hold logic (MUL via PIPELINED_CONTROL_UNIT_MUL_EN).
// Latency: decode reaches ex_* 1 cycle later, mem_* 2, wb_* 3; branch/jump/pc_write/if_flush are combinational.
// Backpressure: load-use/branch-operand stalls and MUL occupancy deassert pc_write/if_id_write; EX gets a bubble (stall) or holds (MUL).
module pipelined_control_unit #(
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic                   clk,
    input  logic                   arst,
    pipelined_control_unit_if.slave cu
);
    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] F7_MUL   = 7'b0000001;

    if (MUL_LATENCY < 1) begin : g_lat_chk
        $error("MUL_LATENCY must be at least 1");
    end

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_2_reg;
        logic       reg_write;
    } ex_ctl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_2_reg;
        logic reg_write;
    } mem_ctl_t;

    typedef struct packed {
        logic mem_2_reg;
        logic reg_write;
    } wb_ctl_t;

    ex_ctl_t               dec;
    logic                  dec_branch;
    logic                  dec_jump;
    logic                  use_rs1;
    logic                  use_rs2;
    ex_ctl_t               ex_q;
    mem_ctl_t              mem_q;
    wb_ctl_t               wb_q;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  ex_hit;
    logic                  mem_hit;
    logic                  hazard_stall;
    logic                  mul_hold;

    always_comb begin
        dec        = '0;
        dec_branch = 1'b0;
        dec_jump   = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (cu.opcode)
            OPC_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
`ifdef PIPELINED_CONTROL_UNIT_MUL_EN
                if (cu.funct7 == F7_MUL) dec.alu_op = 2'b11;
`endif
            end
            OPC_I: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
            end
            OPC_LD: begin
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.mem_2_reg = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
            end
            OPC_ST: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OPC_BR: begin
                dec.alu_op = 2'b01;
                dec_branch = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OPC_JAL: dec_jump = 1'b1;
            default: ;
        endcase
    end

    // ex_rd/mem_rd are zeroed for non-writers, so x0 and stores/branches never match.
    always_comb begin
        ex_hit  = (ex_rd != '0) &&
                  ((use_rs1 && (ex_rd == cu.id_rs1)) || (use_rs2 && (ex_rd == cu.id_rs2)));
        mem_hit = (mem_rd != '0) &&
                  ((use_rs1 && (mem_rd == cu.id_rs1)) || (use_rs2 && (mem_rd == cu.id_rs2)));
        hazard_stall = (ex_q.mem_read && ex_hit)
                     || (dec_branch && ex_q.reg_write && ex_hit)
                     || (dec_branch && mem_q.mem_read && mem_hit);
    end

`ifdef PIPELINED_CONTROL_UNIT_MUL_EN
    localparam int unsigned        CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0]   MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

    typedef enum logic { MUL_IDLE, MUL_BUSY } mul_state_e;

    logic [CNT_W-1:0] mul_cnt;
    logic [CNT_W-1:0] mul_cnt_nxt;
    mul_state_e       mul_state;

    assign mul_state = (mul_cnt != '0) ? MUL_BUSY : MUL_IDLE;
    assign mul_hold  = (mul_state == MUL_BUSY);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) mul_cnt <= '0;
        else      mul_cnt <= mul_cnt_nxt;
    end

    always_comb begin
        mul_cnt_nxt = mul_cnt;
        if (mul_hold)
            mul_cnt_nxt = mul_cnt - CNT_W'(1);
        else if (!hazard_stall && (dec.alu_op == 2'b11))
            mul_cnt_nxt = MUL_LOAD;
    end
`else
    assign mul_hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ex_q   <= '0;
            ex_rd  <= '0;
            mem_q  <= '0;
            mem_rd <= '0;
            wb_q   <= '0;
        end else begin
            wb_q.mem_2_reg <= mem_q.mem_2_reg;
            wb_q.reg_write <= mem_q.reg_write;
            if (mul_hold) begin
                mem_q  <= '0;
                mem_rd <= '0;
            end else begin
                mem_q.mem_read  <= ex_q.mem_read;
                mem_q.mem_write <= ex_q.mem_write;
                mem_q.mem_2_reg <= ex_q.mem_2_reg;
                mem_q.reg_write <= ex_q.reg_write;
                mem_rd          <= ex_rd;
            end
            // A MUL hold freezes EX outright; any pending hazard is re-checked after release.
            if (!mul_hold) begin
                if (hazard_stall) begin
                    ex_q  <= '0;
                    ex_rd <= '0;
                end else begin
                    ex_q  <= dec;
                    ex_rd <= dec.reg_write ? cu.id_rd : '0;
                end
            end
        end
    end

    assign cu.pc_write      = ~(mul_hold | hazard_stall);
    assign cu.if_id_write   = ~(mul_hold | hazard_stall);
    assign cu.if_flush      = (dec_jump | (dec_branch & cu.branch_taken)) & ~hazard_stall & ~mul_hold;
    assign cu.branch        = dec_branch;
    assign cu.jump          = dec_jump;
    assign cu.mul_busy      = mul_hold;
    assign cu.ex_alu_op     = ex_q.alu_op;
    assign cu.ex_alu_src    = ex_q.alu_src;
    assign cu.ex_mem_read   = ex_q.mem_read;
    assign cu.ex_mem_write  = ex_q.mem_write;
    assign cu.ex_mem_2_reg  = ex_q.mem_2_reg;
    assign cu.ex_reg_write  = ex_q.reg_write;
    assign cu.mem_mem_read  = mem_q.mem_read;
    assign cu.mem_mem_write = mem_q.mem_write;
    assign cu.mem_mem_2_reg = mem_q.mem_2_reg;
    assign cu.mem_reg_write = mem_q.reg_write;
    assign cu.wb_mem_2_reg  = wb_q.mem_2_reg;
    assign cu.wb_reg_write  = wb_q.reg_write;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed-vector bench for pipelined_control_unit: decode, stage propagation, stalls, flush, MUL hold, async reset.
module tb_pipelined_control_unit;
    localparam logic [6:0] OPC_NOP = 7'b0000000;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    logic clk = 1'b0;
    logic arst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipelined_control_unit_if #(.REG_ADDR_W(5)) cu_if ();

    pipelined_control_unit #(.MUL_LATENCY(3), .REG_ADDR_W(5)) dut (
        .clk  (clk),
        .arst (arst),
        .cu   (cu_if)
    );

    // {alu_op, alu_src, mem_read, mem_write, mem_2_reg, reg_write}
    function automatic logic [6:0] ex_bits();
        return {cu_if.ex_alu_op, cu_if.ex_alu_src, cu_if.ex_mem_read, cu_if.ex_mem_write,
                cu_if.ex_mem_2_reg, cu_if.ex_reg_write};
    endfunction

    // {mem_read, mem_write, mem_2_reg, reg_write}
    function automatic logic [3:0] mem_bits();
        return {cu_if.mem_mem_read, cu_if.mem_mem_write, cu_if.mem_mem_2_reg, cu_if.mem_reg_write};
    endfunction

    function automatic logic [1:0] wb_bits();
        return {cu_if.wb_mem_2_reg, cu_if.wb_reg_write};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [6:0] f7, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic taken);
        cu_if.opcode       = opc;
        cu_if.funct7       = f7;
        cu_if.id_rs1       = rs1;
        cu_if.id_rs2       = rs2;
        cu_if.id_rd        = rd;
        cu_if.branch_taken = taken;
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        n_vec++;
        if ({ex_bits(), mem_bits(), wb_bits()} !== 13'd0) begin
            n_bad++; $display("FAIL reset_bundles: got %b want 0", {ex_bits(), mem_bits(), wb_bits()});
        end
        n_vec++;
        if ({cu_if.pc_write, cu_if.if_id_write, cu_if.if_flush, cu_if.branch, cu_if.jump, cu_if.mul_busy} !== 6'b110000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 110000",
                {cu_if.pc_write, cu_if.if_id_write, cu_if.if_flush, cu_if.branch, cu_if.jump, cu_if.mul_busy});
        end
        cyc();
        cyc();
        arst = 1'b0;
    endtask

    task automatic test_addi();
        drive(OPC_I, 7'd0, 5'd0, 5'd0, 5'd1, 1'b0);
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        n_vec++;
        if (ex_bits() !== 7'b0010001) begin
            n_bad++; $display("FAIL addi_ex: got %b want 0010001", ex_bits());
        end
        cyc();
        n_vec++;
        if (mem_bits() !== 4'b0001 || ex_bits() !== 7'd0) begin
            n_bad++; $display("FAIL addi_mem: got mem %b ex %b want mem 0001 ex 0", mem_bits(), ex_bits());
        end
        cyc();
        n_vec++;
        if (wb_bits() !== 2'b01) begin
            n_bad++; $display("FAIL addi_wb: got %b want 01", wb_bits());
        end
        cyc();
    endtask

    task automatic test_load_use();
        drive(OPC_LD, 7'd0, 5'd1, 5'd0, 5'd2, 1'b0);
        cyc();
        drive(OPC_R, 7'd0, 5'd2, 5'd4, 5'd3, 1'b0);
        n_vec++;
        if (ex_bits() !== 7'b0011011) begin
            n_bad++; $display("FAIL lw_ex: got %b want 0011011", ex_bits());
        end
        n_vec++;
        if ({cu_if.pc_write, cu_if.if_id_write} !== 2'b00) begin
            n_bad++; $display("FAIL loaduse_stall: got %b want 00", {cu_if.pc_write, cu_if.if_id_write});
        end
        cyc();
        n_vec++;
        if (ex_bits() !== 7'd0 || mem_bits() !== 4'b1011 || cu_if.pc_write !== 1'b1) begin
            n_bad++; $display("FAIL loaduse_bubble: got ex %b mem %b pc %b want ex 0 mem 1011 pc 1",
                ex_bits(), mem_bits(), cu_if.pc_write);
        end
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        n_vec++;
        if (ex_bits() !== 7'b1000001) begin
            n_bad++; $display("FAIL add_late_ex: got %b want 1000001", ex_bits());
        end
        // x0 destination must never stall
        drive(OPC_LD, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        cyc();
        drive(OPC_R, 7'd0, 5'd0, 5'd0, 5'd3, 1'b0);
        n_vec++;
        if (cu_if.pc_write !== 1'b1) begin
            n_bad++; $display("FAIL x0_nostall: got pc_write %b want 1", cu_if.pc_write);
        end
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cyc();
        cyc();
    endtask

    task automatic test_flush();
        drive(OPC_BR, 7'd0, 5'd5, 5'd6, 5'd0, 1'b1);
        n_vec++;
        if ({cu_if.if_flush, cu_if.branch, cu_if.pc_write} !== 3'b111) begin
            n_bad++; $display("FAIL beq_flush: got %b want 111", {cu_if.if_flush, cu_if.branch, cu_if.pc_write});
        end
        cyc();
        drive(OPC_BR, 7'd0, 5'd5, 5'd6, 5'd0, 1'b0);
        n_vec++;
        if (cu_if.if_flush !== 1'b0 || ex_bits() !== 7'b0100000) begin
            n_bad++; $display("FAIL beq_nottaken: got flush %b ex %b want flush 0 ex 0100000",
                cu_if.if_flush, ex_bits());
        end
        cyc();
        drive(OPC_JAL, 7'd0, 5'd0, 5'd0, 5'd1, 1'b0);
        n_vec++;
        if ({cu_if.if_flush, cu_if.jump, cu_if.branch} !== 3'b110) begin
            n_bad++; $display("FAIL jal_flush: got %b want 110", {cu_if.if_flush, cu_if.jump, cu_if.branch});
        end
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        n_vec++;
        if (cu_if.if_flush !== 1'b0 || ex_bits() !== 7'd0) begin
            n_bad++; $display("FAIL flush_clear: got flush %b ex %b want 0 0", cu_if.if_flush, ex_bits());
        end
        cyc();
        cyc();
    endtask

    task automatic test_branch_alu();
        // non-load producer: one stall cycle
        drive(OPC_R, 7'd0, 5'd1, 5'd2, 5'd5, 1'b0);
        cyc();
        drive(OPC_BR, 7'd0, 5'd5, 5'd0, 5'd0, 1'b1);
        n_vec++;
        if ({cu_if.pc_write, cu_if.if_flush} !== 2'b00) begin
            n_bad++; $display("FAIL br_alu_stall: got pc,flush %b want 00", {cu_if.pc_write, cu_if.if_flush});
        end
        cyc();
        n_vec++;
        if ({cu_if.pc_write, cu_if.if_flush} !== 2'b11 || ex_bits() !== 7'd0 || mem_bits() !== 4'b0001) begin
            n_bad++; $display("FAIL br_alu_release: got pc,flush %b ex %b mem %b want 11 0 0001",
                {cu_if.pc_write, cu_if.if_flush}, ex_bits(), mem_bits());
        end
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cyc();
        cyc();
        // load producer: two stall cycles
        drive(OPC_LD, 7'd0, 5'd1, 5'd0, 5'd5, 1'b0);
        cyc();
        drive(OPC_BR, 7'd0, 5'd5, 5'd0, 5'd0, 1'b1);
        n_vec++;
        if ({cu_if.pc_write, cu_if.if_flush} !== 2'b00) begin
            n_bad++; $display("FAIL br_ld_stall1: got %b want 00", {cu_if.pc_write, cu_if.if_flush});
        end
        cyc();
        n_vec++;
        if ({cu_if.pc_write, cu_if.if_flush} !== 2'b00 || mem_bits() !== 4'b1011) begin
            n_bad++; $display("FAIL br_ld_stall2: got %b mem %b want 00 mem 1011",
                {cu_if.pc_write, cu_if.if_flush}, mem_bits());
        end
        cyc();
        n_vec++;
        if ({cu_if.pc_write, cu_if.if_flush} !== 2'b11 || ex_bits() !== 7'd0) begin
            n_bad++; $display("FAIL br_ld_release: got %b ex %b want 11 ex 0",
                {cu_if.pc_write, cu_if.if_flush}, ex_bits());
        end
        cyc();
        // ALU producer feeding a non-branch ALU consumer forwards without stalling
        drive(OPC_R, 7'd0, 5'd1, 5'd2, 5'd5, 1'b0);
        cyc();
        drive(OPC_R, 7'd0, 5'd5, 5'd5, 5'd6, 1'b0);
        n_vec++;
        if (cu_if.pc_write !== 1'b1) begin
            n_bad++; $display("FAIL alu_alu_nostall: got %b want 1", cu_if.pc_write);
        end
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cyc();
        cyc();
    endtask

    task automatic test_mul();
        drive(OPC_I, 7'd0, 5'd0, 5'd0, 5'd1, 1'b0);
        cyc();
        drive(OPC_R, 7'b0000001, 5'd8, 5'd9, 5'd7, 1'b0);
        n_vec++;
        if ({cu_if.pc_write, cu_if.mul_busy} !== 2'b10) begin
            n_bad++; $display("FAIL mul_id: got pc,busy %b want 10", {cu_if.pc_write, cu_if.mul_busy});
        end
        cyc();
        drive(OPC_JAL, 7'd0, 5'd0, 5'd0, 5'd1, 1'b0);
`ifdef PIPELINED_CONTROL_UNIT_MUL_EN
        n_vec++;
        if (ex_bits() !== 7'b1100001 || {cu_if.mul_busy, cu_if.pc_write, cu_if.if_id_write, cu_if.if_flush} !== 4'b1000
            || mem_bits() !== 4'b0001) begin
            n_bad++; $display("FAIL mul_c1: got ex %b busy,pc,ifid,flush %b mem %b want 1100001 1000 0001",
                ex_bits(), {cu_if.mul_busy, cu_if.pc_write, cu_if.if_id_write, cu_if.if_flush}, mem_bits());
        end
        cyc();
        n_vec++;
        if (ex_bits() !== 7'b1100001 || {cu_if.mul_busy, cu_if.pc_write} !== 2'b10
            || mem_bits() !== 4'b0000 || wb_bits() !== 2'b01) begin
            n_bad++; $display("FAIL mul_c2: got ex %b busy,pc %b mem %b wb %b want 1100001 10 0000 01",
                ex_bits(), {cu_if.mul_busy, cu_if.pc_write}, mem_bits(), wb_bits());
        end
        cyc();
        n_vec++;
        if (ex_bits() !== 7'b1100001 || {cu_if.mul_busy, cu_if.pc_write, cu_if.if_flush} !== 3'b011
            || mem_bits() !== 4'b0000) begin
            n_bad++; $display("FAIL mul_c3: got ex %b busy,pc,flush %b mem %b want 1100001 011 0000",
                ex_bits(), {cu_if.mul_busy, cu_if.pc_write, cu_if.if_flush}, mem_bits());
        end
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        n_vec++;
        if (ex_bits() !== 7'd0 || mem_bits() !== 4'b0001) begin
            n_bad++; $display("FAIL mul_release: got ex %b mem %b want 0 0001", ex_bits(), mem_bits());
        end
`else
        n_vec++;
        if (ex_bits() !== 7'b1000001 || {cu_if.mul_busy, cu_if.pc_write, cu_if.if_flush} !== 3'b011) begin
            n_bad++; $display("FAIL mul_plain_r: got ex %b busy,pc,flush %b want 1000001 011",
                ex_bits(), {cu_if.mul_busy, cu_if.pc_write, cu_if.if_flush});
        end
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
`endif
        cyc();
        cyc();
    endtask

    task automatic test_arst_mid();
        drive(OPC_I, 7'd0, 5'd0, 5'd0, 5'd1, 1'b0);
        cyc();
        drive(OPC_R, 7'b0000001, 5'd8, 5'd9, 5'd7, 1'b0);
        cyc();
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef PIPELINED_CONTROL_UNIT_MUL_EN
        n_vec++;
        if (cu_if.mul_busy !== 1'b1) begin
            n_bad++; $display("FAIL arst_pre_busy: got %b want 1", cu_if.mul_busy);
        end
`endif
        n_vec++;
        if (mem_bits() !== 4'b0001) begin
            n_bad++; $display("FAIL arst_pre_mem: got %b want 0001", mem_bits());
        end
        #2 arst = 1'b1;
        #1;
        n_vec++;
        if ({ex_bits(), mem_bits(), wb_bits()} !== 13'd0 || cu_if.mul_busy !== 1'b0) begin
            n_bad++; $display("FAIL arst_async: got bundles %b busy %b want 0 0",
                {ex_bits(), mem_bits(), wb_bits()}, cu_if.mul_busy);
        end
        n_vec++;
        if ({cu_if.pc_write, cu_if.if_id_write, cu_if.if_flush} !== 3'b110) begin
            n_bad++; $display("FAIL arst_ctrl: got %b want 110", {cu_if.pc_write, cu_if.if_id_write, cu_if.if_flush});
        end
        cyc();
        arst = 1'b0;
        cyc();
    endtask

    initial begin
        arst = 1'b0;
        drive(OPC_NOP, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        test_reset();
        test_addi();
        test_load_use();
        test_flush();
        test_branch_alu();
        test_mul();
        test_arst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
